// File: rtl/arb_defs.sv
// Shared definitions for the round-robin 8-to-3 arbiter.
package arb_defs;
  localparam int N_DEF     = 8;
  localparam int IDX_W_DEF = 3;
  localparam int ARB_IDX_W = 3;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/rr_arbiter83_if.sv
// Requester-bank <-> arbiter handshake bundle.
interface rr_arbiter83_if #(
  parameter int N     = 8,
  parameter int IDX_W = 3
);
  logic [N-1:0]     req;
  logic             done;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             revoked;

  modport master (output req, done, input gnt, gnt_idx, gnt_valid, revoked);
  modport slave  (input req, done, output gnt, gnt_idx, gnt_valid, revoked);
endinterface

// File: rtl/rr_arbiter83_prio_enc8.sv
// Lowest-set-bit encoder on an 8-bit vector.
module prio_enc8
  import arb_defs::*;
(
  input  logic [7:0]           in_vec,
  output logic [ARB_IDX_W-1:0] idx,
  output logic                 found
);
  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = |in_vec;
    for (int i = 7; i >= 0; i--) begin
      if (in_vec[i]) idx = i[ARB_IDX_W-1:0];
    end
  end
endmodule

// File: rtl/rr_arbiter83.sv
// Round-robin arbiter: eight requesters, registered one-hot grant plus index,
// grant held until done, request drop, or hold-limit timeout.
module rr_arbiter83
  import arb_defs::*;
#(
  parameter int N        = N_DEF,
  parameter int IDX_W    = IDX_W_DEF,
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst,
  rr_arbiter83_if.slave  bus
);
  localparam int HC_W = $clog2(MAX_HOLD);
  localparam logic [HC_W-1:0] HC_MAX = HC_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [HC_W-1:0]  hcnt_q, hcnt_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             revoked_q, revoked_d;

  logic [2*N-1:0]   req_dbl;
  logic [N-1:0]     req_rot;
  logic [IDX_W-1:0] enc_idx, sel_idx;
  logic             enc_found;
  logic             owner_req, timeout, grant_end;

  // Rotate right by ptr so the search always starts at bit 0 of req_rot.
  always_comb begin
    req_dbl = {bus.req, bus.req} >> ptr_q;
    req_rot = req_dbl[N-1:0];
    sel_idx = enc_idx + ptr_q;  // wraps mod 8 through the 3-bit width
  end

  prio_enc8 u_enc (
    .in_vec (req_rot),
    .idx    (enc_idx),
    .found  (enc_found)
  );

  // Next-state and output-register logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hcnt_d      = hcnt_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    revoked_d   = 1'b0;
    owner_req   = bus.req[gnt_idx_q];
    timeout     = (hcnt_q == HC_MAX);
    grant_end   = bus.done || !owner_req || timeout;
    case (state_q)
      S_IDLE: begin
        if (enc_found) begin
          gnt_d       = N'(1) << sel_idx;
          gnt_idx_d   = sel_idx;
          gnt_valid_d = 1'b1;
          hcnt_d      = '0;
          state_d     = S_GRANT;
        end
      end
      S_GRANT: begin
        if (grant_end) begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_idx_q + 1'b1;
          state_d     = S_IDLE;
          // Only a pure timeout counts as a revocation.
          revoked_d   = timeout && !bus.done && owner_req;
        end else if (hcnt_q != HC_MAX) begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      hcnt_q      <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      revoked_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hcnt_q      <= hcnt_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      revoked_q   <= revoked_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.revoked   = revoked_q;
endmodule

// File: tb/tb_rr_arbiter83.sv
// Bench for rr_arbiter83: directed scenarios plus random traffic, all
// compared every cycle against a behavioural model of the arbitration rules.
module tb_rr_arbiter83;
  localparam int MAXH = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_pass = 0;

  rr_arbiter83_if #(.N(8), .IDX_W(3)) bus ();

  rr_arbiter83 #(.N(8), .IDX_W(3), .MAX_HOLD(MAXH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: who owns the resource, for how many cycles so far.
  bit m_valid = 0;
  int m_idx = 0;
  int m_ptr = 0;
  int m_cyc = 0;
  bit m_rev = 0;
  bit seen_edge = 0;

  always @(posedge clk) begin
    automatic int  sel;
    automatic bit  tmo;
    seen_edge <= 1'b1;
    if (rst) begin
      m_valid <= 0; m_idx <= 0; m_ptr <= 0; m_cyc <= 0; m_rev <= 0;
    end else if (!m_valid) begin
      m_rev <= 0;
      sel = -1;
      for (int k = 0; k < 8; k++)
        if (sel < 0 && bus.req[(m_ptr + k) % 8]) sel = (m_ptr + k) % 8;
      if (sel >= 0) begin
        m_valid <= 1; m_idx <= sel; m_cyc <= 1;
      end
    end else begin
      tmo = (m_cyc >= MAXH);
      if (bus.done || !bus.req[m_idx] || tmo) begin
        m_valid <= 0;
        m_ptr   <= (m_idx + 1) % 8;
        m_rev   <= tmo && !bus.done && bus.req[m_idx];
      end else begin
        m_cyc <= m_cyc + 1;
        m_rev <= 0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (seen_edge) begin
      check("gnt_valid", int'(bus.gnt_valid), int'(m_valid));
      check("gnt", int'(bus.gnt), m_valid ? (1 << m_idx) : 0);
      check("revoked", int'(bus.revoked), int'(m_rev));
      if (m_valid) check("gnt_idx", int'(bus.gnt_idx), m_idx);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    while (!bus.gnt_valid && n < 20) begin
      step();
      n++;
    end
    if (!bus.gnt_valid) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic pulse_done();
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
  endtask

  initial begin
    int cnt;
    rst = 1'b1; bus.req = '0; bus.done = 1'b0;
    repeat (2) step();
    check("rst_gnt", int'(bus.gnt), 0);
    check("rst_valid", int'(bus.gnt_valid), 0);
    check("rst_idx", int'(bus.gnt_idx), 0);
    check("rst_rev", int'(bus.revoked), 0);
    rst = 1'b0;

    // Single request, then done; ptr should now be 3.
    bus.req = 8'b0000_0100;
    step();
    check("single_gnt", int'(bus.gnt), 4);
    check("single_idx", int'(bus.gnt_idx), 2);
    check("single_valid", int'(bus.gnt_valid), 1);
    pulse_done();
    check("single_release", int'(bus.gnt), 0);
    bus.req = 8'b0000_1001;
    wait_grant("ptr3");
    check("ptr3_idx", int'(bus.gnt_idx), 3);
    pulse_done();

    // Round-robin rotation from a fresh reset.
    rst = 1'b1; bus.req = '0; step(); rst = 1'b0;
    bus.req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      wait_grant("rr");
      check("rr_idx", int'(bus.gnt_idx), g % 8);
      pulse_done();
      check("rr_dead", int'(bus.gnt_valid), 0);
    end

    // Wrap-around: serve 5 so ptr=6, then 0 and 1 must win in order.
    bus.req = 8'h20;
    wait_grant("wrap5");
    check("wrap5_idx", int'(bus.gnt_idx), 5);
    pulse_done();
    bus.req = 8'b0000_0011;
    wait_grant("wrap0");
    check("wrap0_idx", int'(bus.gnt_idx), 0);
    pulse_done();
    wait_grant("wrap1");
    check("wrap1_idx", int'(bus.gnt_idx), 1);
    pulse_done();

    // Timeout after MAX_HOLD cycles with a revoked pulse.
    bus.req = 8'b1000_0000;
    wait_grant("tmo");
    cnt = 0;
    while (bus.gnt_valid && cnt < 20) begin
      cnt++;
      step();
    end
    check("tmo_len", cnt, MAXH);
    check("tmo_rev", int'(bus.revoked), 1);
    bus.req = 8'b1000_0001;
    step();
    check("tmo_rev_once", int'(bus.revoked), 0);
    check("tmo_ptr0_idx", int'(bus.gnt_idx), 0);
    // done coinciding with timeout suppresses revoked.
    repeat (3) step();
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    check("tmo_done_valid", int'(bus.gnt_valid), 0);
    check("tmo_done_rev", int'(bus.revoked), 0);
    bus.req = '0;
    step();

    // Request drop mid-grant.
    bus.req = 8'b0000_1000;
    wait_grant("drop");
    check("drop_idx", int'(bus.gnt_idx), 3);
    step();
    bus.req = '0;
    step();
    check("drop_valid", int'(bus.gnt_valid), 0);
    check("drop_rev", int'(bus.revoked), 0);
    bus.req = 8'b0011_0000;
    wait_grant("drop_ptr4");
    check("drop_ptr4_idx", int'(bus.gnt_idx), 4);
    pulse_done();
    bus.req = '0;
    step();

    // Reset in the middle of a grant.
    bus.req = 8'b0010_0000;
    wait_grant("rmid");
    check("rmid_idx", int'(bus.gnt_idx), 5);
    rst = 1'b1;
    step();
    check("rmid_gnt", int'(bus.gnt), 0);
    check("rmid_valid", int'(bus.gnt_valid), 0);
    check("rmid_idx0", int'(bus.gnt_idx), 0);
    check("rmid_rev", int'(bus.revoked), 0);
    rst = 1'b0;
    bus.req = 8'hFF;
    wait_grant("rmid_after");
    check("rmid_after_idx", int'(bus.gnt_idx), 0);
    pulse_done();

    // Random traffic; the model checks every cycle.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(3) == 0) bus.req = 8'($urandom);
      bus.done = ($urandom_range(5) == 0);
      rst = ($urandom_range(99) == 0);
      step();
    end
    rst = 1'b0; bus.req = '0; bus.done = 1'b0;
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rr_arbiter83.md
# rr_arbiter83

Round-robin arbiter sharing one 8-to-3 encoded resource among eight requesters. Each cycle it samples an 8-bit request vector and issues a registered one-hot grant plus its 3-bit binary index. The grant is held until the owner signals completion, drops its request, or exceeds a hold limit. It sits between the requester bank and the shared encoded datapath, driving the datapath's select from `gnt_idx`.

## Interface
Parameters:
- `N`, 8: number of requesters; fixed at 8 in this revision.
- `IDX_W`, 3: index width, log2(N).
- `MAX_HOLD`, 16: maximum grant length in cycles, ≥ 2.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  8  request vector; bit i = requester i.
- `done`  in  1  current grant owner has finished; sampled only in GRANT.
- `gnt`  out  8  one-hot grant, registered; all zero when no grant.
- `gnt_idx`  out  3  binary index of the granted requester; valid only while `gnt_valid`=1.
- `gnt_valid`  out  1  high while a grant is held.
- `revoked`  out  1  one-cycle pulse when a grant ends by timeout.

## Operation
- FSM states: IDLE, GRANT.
- **Reset:**
  - State goes to IDLE.
  - `gnt`=8'b0, `gnt_idx`=3'b0, `gnt_valid`=0, `revoked`=0.
  - Round-robin pointer `ptr`=0; hold counter `hcnt`=0.
- **IDLE:**
  - If `req`=0, stay in IDLE.
  - Otherwise select the first set bit of `req` scanning upward from `ptr` with wrap-around (7→0).
  - Implementation: rotate `req` right by `ptr`, priority-encode the lowest set bit, then add `ptr` modulo 8.
  - Register `gnt`, `gnt_idx` and `gnt_valid`=1, clear `hcnt`, and go to GRANT.
- **GRANT:** the grant ends on the first cycle in which any of the following holds:
  - `done`=1;
  - `req[gnt_idx]`=0;
  - `hcnt`=MAX_HOLD-1.
- **On ending a grant:**
  - Clear `gnt` and `gnt_valid`.
  - Set `ptr` ← `gnt_idx`+1 modulo 8 (7 wraps to 0).
  - Go to IDLE.
  - Pulse `revoked`=1 only if timeout was the sole cause.
- While a grant is held, `hcnt` increments each cycle and saturates at MAX_HOLD-1.
- Requests from non-owners during GRANT are ignored; they are re-evaluated in IDLE.
- **Simultaneous causes:** if `done` and timeout occur in the same cycle, `done` wins and `revoked` stays 0. A request drop with `done` behaves the same as `done` alone.
- **Invariants:**
  - `gnt` is zero or exactly one-hot.
  - `gnt == (gnt_valid << gnt_idx)` at all times.

## Timing
- **Grant latency:** `req` seen in IDLE at edge t → `gnt`/`gnt_valid` high after edge t+1.
- **Release latency:** end condition at edge t → `gnt` low after edge t+1.
- **Mandatory dead cycle:** one IDLE cycle follows every grant. Back-to-back grants are therefore spaced by ≥1 cycle with `gnt_valid`=0.
- **Maximum hold:** a grant is held for at most MAX_HOLD cycles.
- **Fairness:** with all 8 requesting continuously, each requester is served within 8 grants.
- **Reset mid-grant:** all outputs read reset values after the reset edge. `ptr` returns to 0, with no `revoked` pulse.
- All outputs are driven directly from flops; there are no combinational paths from input to output.

## Structure
- Shared package/header (`arb_defs`):
  - state encodings `S_IDLE`=1'b0, `S_GRANT`=1'b1;
  - `N`/`IDX_W` defaults;
  - an `ARB_IDX_W` constant.
- Sub-module `prio_enc8` (combinational): 8-bit input → 3-bit index of the lowest set bit, plus a `found` flag. It is instantiated once on the rotated request vector.
- Top level contains the rotate logic, modular add, FSM, `ptr`, `hcnt` and output registers.

## Test plan
- **Reset and single request:** hold `rst` 2 cycles, then `req`=8'b0000_0100.
  - Expect `gnt`=8'b0000_0100, `gnt_idx`=2 and `gnt_valid`=1 one cycle later.
  - Pulse `done` → `gnt`=0 next cycle; `ptr`=3.
- **Round-robin rotation:** `req`=8'hFF held, `done` pulsed on each grant's first cycle.
  - Expect `gnt_idx` sequence 0,1,2,…,7,0, with one idle cycle between grants.
- **Wrap-around:** with `ptr`=6 (after serving 5), apply `req`=8'b0000_0011.
  - Expect `gnt_idx`=0, then `ptr`=1, then `gnt_idx`=1 on the next grant.
- **Timeout:** with MAX_HOLD=4, hold `req`=8'b1000_0000 with `done`=0.
  - Expect `gnt_valid` high exactly 4 cycles, `revoked` pulsing one cycle, and `ptr`=0.
  - `done` together with timeout → `revoked`=0.
- **Request drop:** granted requester 3 deasserts `req[3]` mid-grant with `done`=0.
  - Expect `gnt`=0 next cycle, `revoked`=0, `ptr`=4.
- **Reset mid-grant:** assert `rst` during a grant to requester 5.
  - Expect all outputs zero after the edge.
  - With `req`=8'hFF afterwards, the first grant after reset goes to index 0.
